// File: rtl/alu_pkg.sv
// Types and constants shared by the ALU scheduler and its datapath.
// Pure declarations: no logic, no latency, no flow control.
package alu_pkg;

    localparam int ALU_W = 4;

    typedef enum logic [2:0] {
        ADD = 3'b000,
        SUB = 3'b001,
        NOT = 3'b010,
        AND = 3'b011,
        OR  = 3'b100,
        XOR = 3'b101,
        LT  = 3'b110,
        EQ  = 3'b111
    } alu_op_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } sched_st_t;

endpackage

// File: rtl/alu_core.sv
// 4-bit ALU op evaluation (a, b, op -> res, car, of).
// Purely combinational: zero latency, no flow control.
module alu_core
    import alu_pkg::*;
(
    input  logic [ALU_W-1:0] a_i,
    input  logic [ALU_W-1:0] b_i,
    input  alu_op_t          op_i,
    output logic [ALU_W-1:0] res_o,
    output logic             car_o,
    output logic             of_o
);

    logic [ALU_W:0] sum;
    logic [ALU_W:0] dif;

    always_comb begin
        sum   = {1'b0, a_i} + {1'b0, b_i};
        dif   = {1'b0, a_i} + {1'b0, ~b_i} + (ALU_W+1)'(1);
        res_o = '0;
        car_o = 1'b0;
        of_o  = 1'b0;
        case (op_i)
            ADD: begin
                {car_o, res_o} = sum;
                of_o = (a_i[ALU_W-1] == b_i[ALU_W-1]) && (res_o[ALU_W-1] != a_i[ALU_W-1]);
            end
            SUB: begin
                // car is carry-out of a + ~b + 1, so car=0 means a borrow occurred
                {car_o, res_o} = dif;
                of_o = (a_i[ALU_W-1] != b_i[ALU_W-1]) && (res_o[ALU_W-1] != a_i[ALU_W-1]);
            end
            NOT:     res_o = ~a_i;
            AND:     res_o = a_i & b_i;
            OR:      res_o = a_i | b_i;
            XOR:     res_o = a_i ^ b_i;
            LT:      res_o = ($signed(a_i) < $signed(b_i)) ? '0 : ALU_W'(1);
            EQ:      res_o = (a_i == b_i) ? '0 : ALU_W'(1);
            default: res_o = '0;
        endcase
    end

endmodule

// File: rtl/alu_sched.sv
// Round-robin share of one ALU among NREQ requesters; accept -> EXEC -> RESP, one op per 3 cycles.
// resp_ready=0 holds RESP with stable outputs and blocks new accepts; ALU_SCHED_STAT_EN adds grant_cnt.
module alu_sched
    import alu_pkg::*;
#(
    parameter int NREQ = 2,
    parameter int IDW  = $clog2(NREQ)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NREQ-1:0]       req_valid,
    output logic [NREQ-1:0]       req_ready,
    input  logic [ALU_W*NREQ-1:0] req_a,
    input  logic [ALU_W*NREQ-1:0] req_b,
    input  logic [3*NREQ-1:0]     req_op,
    output logic                  resp_valid,
    input  logic                  resp_ready,
    output logic [IDW-1:0]        resp_id,
    output logic [ALU_W-1:0]      resp_res,
    output logic                  resp_car,
    output logic                  resp_of
`ifdef ALU_SCHED_STAT_EN
    ,
    output logic [16*NREQ-1:0]    grant_cnt
`endif
);

    sched_st_t        state_q, state_d;
    logic [IDW-1:0]   last_gnt_q, last_gnt_d;
    logic [IDW-1:0]   id_q, id_d;
    logic [ALU_W-1:0] a_q, a_d, b_q, b_d;
    alu_op_t          op_q, op_d;
    logic [ALU_W-1:0] res_q, res_d;
    logic             car_q, car_d, of_q, of_d;

    logic             win_vld;
    logic [IDW-1:0]   win_id;
    logic [IDW-1:0]   idx;
    logic [ALU_W-1:0] sel_a, sel_b;
    alu_op_t          sel_op;
    logic             accept;

    logic [ALU_W-1:0] alu_res;
    logic             alu_car, alu_of;

    // Search starts one past the last winner and wraps at NREQ-1.
    always_comb begin
        win_vld = 1'b0;
        win_id  = last_gnt_q;
        idx     = last_gnt_q;
        for (int k = 0; k < NREQ; k++) begin
            idx = (idx == IDW'(NREQ-1)) ? '0 : idx + 1'b1;
            if (!win_vld && req_valid[idx]) begin
                win_vld = 1'b1;
                win_id  = idx;
            end
        end
        sel_a  = '0;
        sel_b  = '0;
        sel_op = ADD;
        for (int i = 0; i < NREQ; i++) begin
            if (win_id == IDW'(i)) begin
                sel_a  = req_a[ALU_W*i +: ALU_W];
                sel_b  = req_b[ALU_W*i +: ALU_W];
                sel_op = alu_op_t'(req_op[3*i +: 3]);
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        last_gnt_d = last_gnt_q;
        id_d       = id_q;
        a_d        = a_q;
        b_d        = b_q;
        op_d       = op_q;
        res_d      = res_q;
        car_d      = car_q;
        of_d       = of_q;
        accept     = 1'b0;
        case (state_q)
            IDLE: begin
                if (win_vld) begin
                    accept     = 1'b1;
                    a_d        = sel_a;
                    b_d        = sel_b;
                    op_d       = sel_op;
                    id_d       = win_id;
                    last_gnt_d = win_id;
                    state_d    = EXEC;
                end
            end
            EXEC: begin
                res_d   = alu_res;
                car_d   = alu_car;
                of_d    = alu_of;
                state_d = RESP;
            end
            RESP: begin
                if (resp_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Gated by rst_n so the grant cannot leak out while reset is held in IDLE.
    always_comb begin
        req_ready = '0;
        for (int i = 0; i < NREQ; i++) begin
            req_ready[i] = accept && rst_n && (win_id == IDW'(i));
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            last_gnt_q <= IDW'(NREQ-1);
            id_q       <= '0;
            a_q        <= '0;
            b_q        <= '0;
            op_q       <= ADD;
            res_q      <= '0;
            car_q      <= 1'b0;
            of_q       <= 1'b0;
        end else begin
            state_q    <= state_d;
            last_gnt_q <= last_gnt_d;
            id_q       <= id_d;
            a_q        <= a_d;
            b_q        <= b_d;
            op_q       <= op_d;
            res_q      <= res_d;
            car_q      <= car_d;
            of_q       <= of_d;
        end
    end

    alu_core u_alu_core (
        .a_i   (a_q),
        .b_i   (b_q),
        .op_i  (op_q),
        .res_o (alu_res),
        .car_o (alu_car),
        .of_o  (alu_of)
    );

    assign resp_valid = (state_q == RESP);
    assign resp_id    = id_q;
    assign resp_res   = res_q;
    assign resp_car   = car_q;
    assign resp_of    = of_q;

`ifdef ALU_SCHED_STAT_EN
    logic [15:0] cnt_q [NREQ];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREQ; i++) cnt_q[i] <= '0;
        end else begin
            for (int i = 0; i < NREQ; i++) begin
                if (accept && (win_id == IDW'(i)) && (cnt_q[i] != 16'hFFFF)) begin
                    cnt_q[i] <= cnt_q[i] + 16'd1;
                end
            end
        end
    end

    for (genvar g = 0; g < NREQ; g++) begin : g_cnt
        assign grant_cnt[16*g +: 16] = cnt_q[g];
    end
`endif

endmodule

// File: tb/tb_alu_sched.sv
// Bench for alu_sched: directed vector table, multi-cycle corner sequences, randomized scoreboard run.
module tb_alu_sched;

    localparam int NREQ = 2;
    localparam int IDW  = 1;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [NREQ-1:0]   req_valid = '0;
    logic [NREQ-1:0]   req_ready;
    logic [4*NREQ-1:0] req_a = '0;
    logic [4*NREQ-1:0] req_b = '0;
    logic [3*NREQ-1:0] req_op = '0;
    logic              resp_valid;
    logic              resp_ready = 1'b1;
    logic [IDW-1:0]    resp_id;
    logic [3:0]        resp_res;
    logic              resp_car;
    logic              resp_of;
`ifdef ALU_SCHED_STAT_EN
    logic [16*NREQ-1:0] grant_cnt;
`endif

    alu_sched #(.NREQ(NREQ)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_a      (req_a),
        .req_b      (req_b),
        .req_op     (req_op),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_id    (resp_id),
        .resp_res   (resp_res),
        .resp_car   (resp_car),
        .resp_of    (resp_of)
`ifdef ALU_SCHED_STAT_EN
        ,
        .grant_cnt  (grant_cnt)
`endif
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_err = 0;

    typedef struct {
        int         id;
        logic [3:0] a;
        logic [3:0] b;
        logic [2:0] op;
        logic [3:0] res;
        logic       car;
        logic       of;
    } vec_t;

    typedef struct {
        int         id;
        logic [3:0] r;
        logic       c;
        logic       o;
    } exp_t;

    task automatic chk(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    function automatic int sgn(input logic [3:0] v);
        return (v >= 4'd8) ? int'(v) - 16 : int'(v);
    endfunction

    // Reference ALU from integer arithmetic on unsigned/signed values.
    function automatic void ref_alu(input logic [3:0] a, input logic [3:0] b, input logic [2:0] op,
                                    output logic [3:0] r, output logic c, output logic o);
        int ua, ub, sa, sb, t;
        ua = int'(a); ub = int'(b); sa = sgn(a); sb = sgn(b);
        r = 4'd0; c = 1'b0; o = 1'b0;
        case (op)
            3'd0: begin t = ua + ub; r = t[3:0]; c = (t > 15); o = (sa + sb > 7) || (sa + sb < -8); end
            3'd1: begin t = ua - ub; r = t[3:0]; c = (ua >= ub); o = (sa - sb > 7) || (sa - sb < -8); end
            3'd2: begin t = 15 - ua; r = t[3:0]; end
            3'd3: r = a & b;
            3'd4: r = a | b;
            3'd5: r = a ^ b;
            3'd6: r = (sa < sb) ? 4'd0 : 4'd1;
            default: r = (ua == ub) ? 4'd0 : 4'd1;
        endcase
    endfunction

    task automatic set_req(input int id, input logic v, input logic [3:0] a, input logic [3:0] b,
                           input logic [2:0] op);
        req_valid[id]      = v;
        req_a[4*id +: 4]   = a;
        req_b[4*id +: 4]   = b;
        req_op[3*id +: 3]  = op;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic wait_ready(input int id, input string nm);
        int k;
        k = 0;
        #1;
        while (!req_ready[id] && k < 20) begin
            @(negedge clk); #1; k++;
        end
        chk({nm, "/accept"}, int'(req_ready[id]), 1);
    endtask

    task automatic wait_resp(input string nm, output int lat);
        lat = 1;
        #1;
        while (!resp_valid && lat < 20) begin
            @(negedge clk); #1; lat++;
        end
        chk({nm, "/resp_seen"}, int'(resp_valid), 1);
    endtask

    task automatic run_vec(input vec_t v, input string nm);
        int lat;
        @(negedge clk);
        set_req(v.id, 1'b1, v.a, v.b, v.op);
        wait_ready(v.id, nm);
        @(posedge clk);
        @(negedge clk);
        req_valid[v.id] = 1'b0;
        wait_resp(nm, lat);
        chk({nm, "/latency"}, lat, 2);
        chk({nm, "/id"},  int'(resp_id),  v.id);
        chk({nm, "/res"}, int'(resp_res), int'(v.res));
        chk({nm, "/car"}, int'(resp_car), int'(v.car));
        chk({nm, "/of"},  int'(resp_of),  int'(v.of));
        @(posedge clk);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached before summary");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vt[13];
        int   gid[4], gcyc[4], rid[4];
        int   ng, nr, lat, seen, grants, last_m, w, g;
        logic [NREQ-1:0] pending;
        logic [3:0] pa[NREQ], pb[NREQ];
        logic [2:0] po[NREQ];
        logic [3:0] er;
        logic       ec, eo;
        exp_t       q[$];
        exp_t       e;

        vt[0]  = '{0, 4'h7, 4'h1, 3'b000, 4'h8, 1'b0, 1'b1};
        vt[1]  = '{1, 4'h2, 4'h3, 3'b001, 4'hF, 1'b0, 1'b0};
        vt[2]  = '{1, 4'h8, 4'h1, 3'b001, 4'h7, 1'b1, 1'b1};
        vt[3]  = '{0, 4'hF, 4'h1, 3'b110, 4'h0, 1'b0, 1'b0};
        vt[4]  = '{0, 4'h5, 4'h5, 3'b111, 4'h0, 1'b0, 1'b0};
        vt[5]  = '{1, 4'h5, 4'h6, 3'b111, 4'h1, 1'b0, 1'b0};
        vt[6]  = '{0, 4'hA, 4'hC, 3'b010, 4'h5, 1'b0, 1'b0};
        vt[7]  = '{1, 4'hC, 4'hA, 3'b011, 4'h8, 1'b0, 1'b0};
        vt[8]  = '{0, 4'hC, 4'hA, 3'b100, 4'hE, 1'b0, 1'b0};
        vt[9]  = '{1, 4'hC, 4'hA, 3'b101, 4'h6, 1'b0, 1'b0};
        vt[10] = '{0, 4'h9, 4'h9, 3'b000, 4'h2, 1'b1, 1'b1};
        vt[11] = '{1, 4'h1, 4'h7, 3'b110, 4'h0, 1'b0, 1'b0};
        vt[12] = '{0, 4'h7, 4'hF, 3'b110, 4'h1, 1'b0, 1'b0};

        // Reset state, with a request pending to prove req_ready is held low
        req_valid[0] = 1'b1;
        #12;
        chk("rst/req_ready",  int'(req_ready),  0);
        chk("rst/resp_valid", int'(resp_valid), 0);
        chk("rst/resp_id",    int'(resp_id),    0);
        chk("rst/resp_res",   int'(resp_res),   0);
        chk("rst/resp_car",   int'(resp_car),   0);
        chk("rst/resp_of",    int'(resp_of),    0);
        req_valid = '0;
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 13; i++) run_vec(vt[i], $sformatf("vec%0d", i));

        // Contention: both valid from reset, grants alternate starting at 0
        do_reset();
        set_req(0, 1'b1, 4'h1, 4'h1, 3'b000);
        set_req(1, 1'b1, 4'h2, 4'h1, 3'b000);
        ng = 0; nr = 0;
        for (int c = 0; c < 14; c++) begin
            if (c > 0) @(negedge clk);
            #1;
            if (req_ready != '0 && ng < 4) begin
                gid[ng] = req_ready[1] ? 1 : 0; gcyc[ng] = cyc; ng++;
            end
            if (resp_valid && nr < 4) begin
                rid[nr] = int'(resp_id); nr++;
            end
        end
        req_valid = '0;
        chk("cont/grant_count", ng, 4);
        chk("cont/resp_count",  nr, 4);
        for (int k = 0; k < 4; k++) begin
            if (k < ng) chk($sformatf("cont/grant%0d", k), gid[k], k % 2);
            if (k < nr) chk($sformatf("cont/resp_id%0d", k), rid[k], k % 2);
            if (k > 0 && k < ng) chk($sformatf("cont/spacing%0d", k), gcyc[k] - gcyc[k-1], 3);
        end
        repeat (4) @(negedge clk);

        // Back-pressure: RESP held for 5 cycles, competing request not accepted
        resp_ready = 1'b0;
        @(negedge clk);
        set_req(0, 1'b1, 4'h3, 4'h4, 3'b000);
        wait_ready(0, "bp");
        @(posedge clk);
        @(negedge clk);
        req_valid[0] = 1'b0;
        set_req(1, 1'b1, 4'h1, 4'h1, 3'b000);
        wait_resp("bp", lat);
        for (int k = 0; k < 5; k++) begin
            if (k > 0) begin @(negedge clk); #1; end
            chk($sformatf("bp/valid%0d", k), int'(resp_valid), 1);
            chk($sformatf("bp/res%0d", k),   int'(resp_res),   7);
            chk($sformatf("bp/id%0d", k),    int'(resp_id),    0);
            chk($sformatf("bp/ready%0d", k), int'(req_ready),  0);
        end
        resp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk); #1;
        chk("bp/done_valid", int'(resp_valid), 0);
        chk("bp/next_ready", int'(req_ready), 2);
        @(posedge clk);
        @(negedge clk);
        req_valid[1] = 1'b0;
        wait_resp("bp2", lat);
        chk("bp2/id",  int'(resp_id),  1);
        chk("bp2/res", int'(resp_res), 2);
        @(posedge clk);

        // Reset during EXEC of a requester-0 op
        @(negedge clk);
        set_req(0, 1'b1, 4'h9, 4'h9, 3'b000);
        wait_ready(0, "rmid");
        @(posedge clk);
        @(negedge clk);
        req_valid[0] = 1'b0;
        req_valid[1] = 1'b1;
        rst_n = 1'b0;
        #1;
        chk("rmid/resp_valid", int'(resp_valid), 0);
        chk("rmid/resp_id",    int'(resp_id),    0);
        chk("rmid/resp_res",   int'(resp_res),   0);
        chk("rmid/resp_car",   int'(resp_car),   0);
        chk("rmid/resp_of",    int'(resp_of),    0);
        chk("rmid/req_ready",  int'(req_ready),  0);
        req_valid[1] = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        repeat (6) begin
            @(negedge clk); #1;
            if (resp_valid) seen++;
        end
        chk("rmid/no_resp", seen, 0);
        req_valid = 2'b11;
        #1;
        chk("rmid/first_grant", int'(req_ready), 1);
        req_valid = '0;
        repeat (2) @(negedge clk);

        // Randomized traffic against the scoreboard
        do_reset();
        last_m  = NREQ - 1;
        pending = '0;
        grants  = 0;
        for (int c = 0; c < 800 && grants < 60; c++) begin
            @(negedge clk);
            resp_ready = ($urandom_range(0, 3) != 0);
            for (int i = 0; i < NREQ; i++) begin
                if (!pending[i]) begin
                    if ($urandom_range(0, 2) == 0) begin
                        pa[i] = 4'($urandom_range(0, 15));
                        pb[i] = 4'($urandom_range(0, 15));
                        po[i] = 3'($urandom_range(0, 7));
                        pending[i] = 1'b1;
                        set_req(i, 1'b1, pa[i], pb[i], po[i]);
                    end else begin
                        req_valid[i] = 1'b0;
                    end
                end
            end
            #1;
            if (req_ready != '0) begin
                w = -1;
                for (int k = 1; k <= NREQ; k++) begin
                    if (w < 0 && req_valid[(last_m + k) % NREQ]) w = (last_m + k) % NREQ;
                end
                g = 0;
                for (int i = 0; i < NREQ; i++) if (req_ready[i]) g = i;
                chk("rnd/onehot", $countones(req_ready), 1);
                chk("rnd/winner", g, w);
                chk("rnd/grant_while_busy", q.size(), 0);
                ref_alu(pa[g], pb[g], po[g], er, ec, eo);
                q.push_back('{g, er, ec, eo});
                last_m = g;
                pending[g] = 1'b0;
                grants++;
            end
            if (resp_valid && resp_ready) begin
                if (q.size() == 0) begin
                    chk("rnd/spurious_resp", 1, 0);
                end else begin
                    e = q.pop_front();
                    chk("rnd/id",  int'(resp_id),  e.id);
                    chk("rnd/res", int'(resp_res), int'(e.r));
                    chk("rnd/car", int'(resp_car), int'(e.c));
                    chk("rnd/of",  int'(resp_of),  int'(e.o));
                end
            end
        end
        @(negedge clk);
        req_valid  = '0;
        resp_ready = 1'b1;
        for (int c = 0; c < 6; c++) begin
            #1;
            if (resp_valid && q.size() > 0) begin
                e = q.pop_front();
                chk("drain/id",  int'(resp_id),  e.id);
                chk("drain/res", int'(resp_res), int'(e.r));
                chk("drain/car", int'(resp_car), int'(e.c));
                chk("drain/of",  int'(resp_of),  int'(e.o));
            end
            @(negedge clk);
        end
        chk("rnd/grants_made", int'(grants >= 20), 1);
        chk("rnd/queue_empty", q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/alu_sched.md
# alu_sched

Round-robin scheduler that shares one 4-bit ALU datapath between `NREQ` requesters. Each requester issues an operation through a valid/ready handshake. The scheduler grants one request at a time, registers its operands, executes, and returns result and flags on a shared response channel tagged with the requester id. It sits between the lab top-level request sources (switch/key decoders) and the ALU, and its response drives the seven-segment and LED display logic.

## Interface
- `NREQ`, default 2: number of requesters, legal range 2..4.
- `IDW`, default `$clog2(NREQ)`: width of the response id; never set explicitly.
- `clk`  in  1  sole clock; everything is on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `req_valid`  in  NREQ  per-requester request valid.
- `req_ready`  out  NREQ  per-requester accept; one-hot or zero.
- `req_a`  in  4*NREQ  operand A; requester i uses bits [4i+3:4i].
- `req_b`  in  4*NREQ  operand B, same packing as `req_a`.
- `req_op`  in  3*NREQ  op code; requester i uses bits [3i+2:3i].
- `resp_valid`  out  1  response valid.
- `resp_ready`  in  1  response consumed.
- `resp_id`  out  IDW  index of the requester this response belongs to.
- `resp_res`  out  4  result.
- `resp_car`  out  1  carry/borrow-out.
- `resp_of`  out  1  signed overflow.

## Operation
- FSM states are IDLE, EXEC and RESP. Reset state is IDLE.
- **IDLE**
  - If any `req_valid` is set, pick the winner by round robin, starting the search at `last_gnt+1` mod NREQ.
  - Drive `req_ready[winner]`=1 combinationally.
  - Latch a, b, op and id. Update `last_gnt`=winner. Go to EXEC.
- **EXEC**
  - Apply the latched operands to the ALU.
  - Register res, car and of into the response registers. Go to RESP.
- **RESP**
  - Hold `resp_valid`=1 with stable id and data.
  - When `resp_ready`=1, go to IDLE.
- **Op codes** (car=of=0 except where stated):
  - 000 add: {car,res}=a+b; of=(a[3]==b[3])&&(res[3]!=a[3]).
  - 001 sub: {car,res}=a+~b+1; of=(a[3]!=b[3])&&(res[3]!=a[3]).
  - 010 res=~a.
  - 011 res=a&b.
  - 100 res=a|b.
  - 101 res=a^b.
  - 110 signed compare: res=0 if a<b, else res=1.
  - 111 equality: res=0 if a==b, else res=1.
- **Requester rules**
  - A requester holds `req_valid` and its operands stable until it sees `req_ready`.
  - `req_ready` is 0 in EXEC and RESP; at most one bit is ever set.
  - `req_ready` depends combinationally on `req_valid`. `req_valid` must never depend on `req_ready`.
- **Reset values**: `req_ready`=0, `resp_valid`=0, `resp_id`=0, `resp_res`=0, `resp_car`=0, `resp_of`=0, `last_gnt`=NREQ-1 (requester 0 wins first).
- Reset asserted mid-operation abandons the transaction immediately. No response is produced for it.

## Timing
- **Latency**: accepted at edge T, `resp_valid` rises after edge T+2. With `resp_ready` tied high, the next accept is at T+3.
- **Throughput**: one operation per 3 cycles at best.
- **Fairness**: with all requesters continuously valid, grants rotate 0,1,...,NREQ-1,0. Worst-case wait is 3*NREQ cycles plus downstream stall time.
- **Back-pressure**: `resp_ready`=0 holds RESP indefinitely. Outputs stay stable and no new request is accepted.
- **Simultaneous events**: a `req_valid` that drops in IDLE without a grant is simply not served. Winners are only chosen in IDLE.
- **Wrap-around**: the round-robin search wraps from NREQ-1 to 0.

## Configuration
- `ALU_SCHED_STAT_EN` defined: adds output `grant_cnt` (16*NREQ bits, packed like `req_a`).
  - One counter per requester, incremented on each accept.
  - Counters saturate at 16'hFFFF and reset to 0.
- `ALU_SCHED_STAT_EN` undefined: no port, no counters. Behaviour is otherwise identical.

## Structure
- **Shared package `alu_pkg`**:
  - `alu_op_t`, a 3-bit enum: ADD, SUB, NOT, AND, OR, XOR, LT, EQ.
  - State enum `sched_st_t`.
  - Constant `ALU_W`=4.
- **Sub-modules**:
  - Op evaluation lives in combinational sub-module `alu_core` (a, b, op → res, car, of). The top instantiates it once.
  - The round-robin picker stays inline.

## Test plan
- **Single add**: req0 a=4'h7, b=4'h1, op=000. Expect accept at T, `resp_valid` at T+2 with res=4'h8, car=0, of=1, id=0.
- **Sub borrow**: req1 a=4'h2, b=4'h3, op=001. Expect res=4'hF, car=0, of=0, id=1. Then a=4'h8, b=4'h1 → res=4'h7, of=1.
- **Contention**: req0 and req1 both valid continuously from reset. Expect grants in order 0,1,0,1 and responses with id 0,1,0,1, each 3 cycles apart.
- **Back-pressure**: hold `resp_ready`=0 for 5 cycles in RESP. Expect `resp_valid` and data stable, `req_ready`=0 throughout, and the transaction completing on the first `resp_ready`=1.
- **Compare/equal**: a=4'hF(-1), b=4'h1, op=110 → res=0. a=b=4'h5, op=111 → res=0. a=4'h5, b=4'h6, op=111 → res=1.
- **Reset mid-op**: assert `rst_n`=0 in EXEC. Expect all outputs 0 asynchronously, no response after release, and the next grant going to requester 0.
